// File: rtl/gvp_store_packer.sv
// gvp store packer: snapshots gvp vector/source data on store triggers and streams framed words over AXI-stream.
// Optional build macro GVP_PACK_TIMESTAMP_EN adds a 64-bit timestamp after every frame marker.
module gvp_store_packer #(
  parameter int NUM_SRC    = 8,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          a_clk,
  input  logic                          reset,
  input  logic [1:0]                    store_data,
  input  logic                          gvp_finished,
  input  logic [31:0]                   section,
  input  logic [31:0]                   x,
  input  logic [31:0]                   y,
  input  logic [31:0]                   z,
  input  logic [31:0]                   u,
  input  logic [NUM_SRC-1:0]            src_mask,
  input  logic [32*NUM_SRC-1:0]         srcs,
  output logic [31:0]                   M_AXIS_tdata,
  output logic                          M_AXIS_tvalid,
  input  logic                          M_AXIS_tready,
  output logic                          M_AXIS_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          busy,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
`ifdef GVP_PACK_TIMESTAMP_EN
  localparam int          TSW     = 2;
  localparam logic [15:0] MK_FULL = 16'h4857;
  localparam logic [15:0] MK_SRC  = 16'h4454;
  localparam logic [15:0] MK_END  = 16'h454F;
`else
  localparam int          TSW     = 0;
  localparam logic [15:0] MK_FULL = 16'h4856;
  localparam logic [15:0] MK_SRC  = 16'h4453;
  localparam logic [15:0] MK_END  = 16'h454E;
`endif

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  localparam logic [1:0] K_SRC  = 2'd1;
  localparam logic [1:0] K_FULL = 2'd2;
  localparam logic [1:0] K_END  = 2'd3;

  logic [0:0]             r_state;
  logic [1:0]             r_sd_prev;
  logic                   r_fin_prev;
  logic                   r_end_pend;
  logic [1:0]             r_kind;
  logic [3:0]             r_idx;
  logic [NUM_SRC-1:0]     r_mask;
  logic [NUM_SRC-1:0]     r_rem;
  logic [31:0]            r_section, r_x, r_y, r_z, r_u;
  logic [32*NUM_SRC-1:0]  r_srcs;
  logic                   r_overflow;
  logic [15:0]            r_drop;
`ifdef GVP_PACK_TIMESTAMP_EN
  logic [63:0]            r_ts, r_ts_snap, r_end_ts;
`endif

  logic [32:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [FW-1:0]          r_count;
  logic [31:0]            r_tdata;
  logic                   r_tvalid, r_tlast;

  logic                   w_trig, w_fin_rise, w_end_req;
  logic [5:0]             w_need_store;
  logic [FW-1:0]          w_free;
  logic                   w_store_ok, w_end_ok, w_end_ok_emit;
  logic                   w_ld_store, w_ld_end, w_to_idle, w_pend_set, w_pend_clr, w_drop;
  logic [NUM_SRC-1:0]     w_onehot, w_rem_next;
  logic [31:0]            w_src, w_word;
  logic [15:0]            w_mask16, w_mk_hi;
  logic [3:0]             w_fixlen, w_hidx;
  logic                   w_in_fixed, w_last;
  logic                   w_push, w_pop, w_load;

  assign w_trig     = (r_sd_prev == 2'b00) && (store_data != 2'b00);
  assign w_fin_rise = gvp_finished & ~r_fin_prev;
  assign w_end_req  = r_end_pend | w_fin_rise;

  always_comb begin
    w_need_store = 6'd1 + 6'(TSW);
    if (store_data == 2'd2) w_need_store = w_need_store + 6'd5;
    for (int unsigned i = 0; i < NUM_SRC; i++) w_need_store = w_need_store + 6'(src_mask[i]);
  end

  assign w_free        = FW'(FIFO_DEPTH) - r_count;
  assign w_store_ok    = w_free >= FW'(w_need_store);
  assign w_end_ok      = w_free >= FW'(1 + TSW);
  // At the tlast edge one more word lands in the FIFO, so the end frame needs one extra slot.
  assign w_end_ok_emit = w_free > FW'(1 + TSW);

  always_comb begin
    w_ld_store = 1'b0;
    w_ld_end   = 1'b0;
    w_to_idle  = 1'b0;
    w_pend_set = 1'b0;
    w_pend_clr = 1'b0;
    w_drop     = 1'b0;
    if (r_state == S_IDLE) begin
      if (w_trig && w_store_ok) begin
        w_ld_store = 1'b1;
        w_pend_set = w_fin_rise;
      end else begin
        w_drop = w_trig;
        if (w_end_req && w_end_ok) begin
          w_ld_end   = 1'b1;
          w_pend_clr = 1'b1;
        end else begin
          w_pend_set = w_fin_rise;
        end
      end
    end else begin
      w_drop = w_trig;
      if (w_last && w_end_req && w_end_ok_emit) begin
        w_ld_end   = 1'b1;
        w_pend_clr = 1'b1;
      end else begin
        w_to_idle  = w_last;
        w_pend_set = w_fin_rise;
      end
    end
  end

  always_comb begin
    w_mask16 = '0;
    w_mask16[NUM_SRC-1:0] = r_mask;
    case (r_kind)
      K_FULL:  w_mk_hi = MK_FULL;
      K_END:   w_mk_hi = MK_END;
      default: w_mk_hi = MK_SRC;
    endcase
  end

  // Sources are walked by repeatedly isolating and clearing the lowest set bit of the remaining mask.
  always_comb begin
    w_onehot   = r_rem & ~(r_rem - NUM_SRC'(1));
    w_rem_next = r_rem & (r_rem - NUM_SRC'(1));
    w_src      = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++)
      if (w_onehot[i]) w_src = r_srcs[32*i +: 32];
    w_fixlen   = ((r_kind == K_FULL) ? 4'd6 : 4'd1) + 4'(TSW);
    w_hidx     = r_idx - 4'(1 + TSW);
    w_in_fixed = r_idx < w_fixlen;
    w_word     = w_src;
    if (w_in_fixed) begin
      if (r_idx == 4'd0) w_word = {w_mk_hi, w_mask16};
`ifdef GVP_PACK_TIMESTAMP_EN
      else if (r_idx == 4'd1) w_word = r_ts_snap[31:0];
      else if (r_idx == 4'd2) w_word = r_ts_snap[63:32];
`endif
      else begin
        case (w_hidx)
          4'd0:    w_word = r_section;
          4'd1:    w_word = r_x;
          4'd2:    w_word = r_y;
          4'd3:    w_word = r_z;
          default: w_word = r_u;
        endcase
      end
      w_last = (r_idx == w_fixlen - 4'd1) && (r_rem == '0);
    end else begin
      w_last = (w_rem_next == '0);
    end
  end

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sd_prev  <= 2'b00;
      r_fin_prev <= 1'b0;
      r_end_pend <= 1'b0;
      r_kind     <= K_SRC;
      r_idx      <= '0;
      r_mask     <= '0;
      r_rem      <= '0;
      r_section  <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_u        <= '0;
      r_srcs     <= '0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
    end else begin
      r_sd_prev  <= store_data;
      r_fin_prev <= gvp_finished;
      if (w_pend_clr)      r_end_pend <= 1'b0;
      else if (w_pend_set) r_end_pend <= 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
      if (r_state == S_EMIT) begin
        if (w_in_fixed) r_idx <= r_idx + 4'd1;
        else            r_rem <= w_rem_next;
      end
      if (w_ld_store) begin
        r_state   <= S_EMIT;
        r_kind    <= (store_data == 2'd2) ? K_FULL : K_SRC;
        r_idx     <= '0;
        r_mask    <= src_mask;
        r_rem     <= src_mask;
        r_section <= section;
        r_x       <= x;
        r_y       <= y;
        r_z       <= z;
        r_u       <= u;
        r_srcs    <= srcs;
      end else if (w_ld_end) begin
        r_state <= S_EMIT;
        r_kind  <= K_END;
        r_idx   <= '0;
        r_mask  <= '0;
        r_rem   <= '0;
      end else if (w_to_idle) begin
        r_state <= S_IDLE;
      end
    end
  end

`ifdef GVP_PACK_TIMESTAMP_EN
  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      r_ts      <= '0;
      r_ts_snap <= '0;
      r_end_ts  <= '0;
    end else begin
      r_ts <= r_ts + 64'd1;
      if (w_fin_rise && !r_end_pend) r_end_ts <= r_ts;
      if (w_ld_store)    r_ts_snap <= r_ts;
      else if (w_ld_end) r_ts_snap <= w_fin_rise ? r_ts : r_end_ts;
    end
  end
`endif

  assign w_push = (r_state == S_EMIT);
  assign w_pop  = r_tvalid & M_AXIS_tready;
  assign w_load = (r_wptr != r_rptr) && (!r_tvalid || M_AXIS_tready);

  always_ff @(posedge a_clk) begin
    if (w_push) r_mem[r_wptr] <= {w_last, w_word};
  end

  // Occupancy counts the output register too, so admission sees the true total capacity.
  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      r_count <= r_count + FW'(w_push) - FW'(w_pop);
      if (w_load) begin
        r_rptr   <= r_rptr + AW'(1);
        r_tdata  <= r_mem[r_rptr][31:0];
        r_tlast  <= r_mem[r_rptr][32];
        r_tvalid <= 1'b1;
      end else if (w_pop) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
    end
  end

  assign M_AXIS_tdata  = r_tdata;
  assign M_AXIS_tvalid = r_tvalid;
  assign M_AXIS_tlast  = r_tlast;
  assign fill_level    = r_count;
  assign busy          = (r_state == S_EMIT);
  assign overflow      = r_overflow;
  assign drop_count    = r_drop;

endmodule

// File: tb/tb_gvp_store_packer.sv
// Scoreboard bench for gvp_store_packer: directed triggers push expected words, a monitor checks the stream.
module tb_gvp_store_packer;

  localparam int NUM_SRC = 8;
  localparam int DEPTH   = 64;
  localparam logic [31:0] SEC = 32'h0000_0007;
  localparam logic [31:0] XV  = 32'h1111_1111;
  localparam logic [31:0] YV  = 32'h2222_2222;
  localparam logic [31:0] ZV  = 32'h3333_3333;
  localparam logic [31:0] UV  = 32'h4444_4444;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   store_data;
  logic         fin;
  logic [31:0]  section, x, y, z, u;
  logic [7:0]   mask;
  logic [255:0] srcs;
  logic [31:0]  tdata;
  logic         tvalid, tready, tlast;
  logic [6:0]   fill;
  logic         busy, ovf;
  logic [15:0]  drops;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;

  always #5 clk = ~clk;

  gvp_store_packer #(.NUM_SRC(NUM_SRC), .FIFO_DEPTH(DEPTH)) dut (
    .a_clk(clk), .reset(rst), .store_data(store_data), .gvp_finished(fin),
    .section(section), .x(x), .y(y), .z(z), .u(u),
    .src_mask(mask), .srcs(srcs),
    .M_AXIS_tdata(tdata), .M_AXIS_tvalid(tvalid), .M_AXIS_tready(tready), .M_AXIS_tlast(tlast),
    .fill_level(fill), .busy(busy), .overflow(ovf), .drop_count(drops)
  );

  function automatic logic [31:0] src_val(int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic exp_frame(int t, logic [7:0] m);
    logic [31:0] w[$];
    w.push_back({(t == 2) ? 16'h4856 : 16'h4453, 8'h00, m});
    if (t == 2) begin
      w.push_back(SEC); w.push_back(XV); w.push_back(YV); w.push_back(ZV); w.push_back(UV);
    end
    for (int i = 0; i < NUM_SRC; i++) if (m[i]) w.push_back(src_val(i));
    for (int k = 0; k < w.size(); k++) exp_q.push_back({(k == w.size() - 1), w[k]});
  endtask

  task automatic drain(string name);
    int n = 0;
    tready = 1'b1;
    while ((exp_q.size() != 0 || tvalid) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d words still pending expected 0", name, exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (tvalid && tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_word: got last=%0b data=%h expected no word", tlast, tdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({tlast, tdata} !== mon_exp) begin
          errors++;
          $display("FAIL stream_word: got last=%0b data=%h expected last=%0b data=%h",
                   tlast, tdata, mon_exp[32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; store_data = 2'b00; fin = 1'b0; tready = 1'b0;
    section = SEC; x = XV; y = YV; z = ZV; u = UV; mask = '0;
    for (int i = 0; i < NUM_SRC; i++) srcs[32*i +: 32] = src_val(i);
    #1 rst = 1'b1;
    tick(); tick();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_fill", fill, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drops", drops, 0);
    rst = 1'b0;
    tick();

    // Type 2, mask 0x05, latency to tvalid
    tready = 1'b1; mask = 8'h05;
    exp_frame(2, 8'h05);
    store_data = 2'd2;
    tick();
    chk("t1_busy", busy, 1);
    chk("t1_tvalid_T", tvalid, 0);
    store_data = 2'd0;
    tick();
    chk("t1_tvalid_T1", tvalid, 0);
    tick();
    chk("t1_tvalid_T2", tvalid, 1);
    chk("t1_marker", tdata, 32'h4856_0005);
    drain("t1_drain");
    chk("t1_idle", busy, 0);

    // Type 1, zero mask
    mask = 8'h00;
    exp_frame(1, 8'h00);
    store_data = 2'd1;
    tick();
    store_data = 2'd0;
    drain("t2_drain");

    // Store and finish on the same edge
    mask = 8'h03;
    exp_frame(1, 8'h03);
    exp_q.push_back({1'b1, 32'h454E_0000});
    store_data = 2'd1; fin = 1'b1;
    tick();
    store_data = 2'd0;
    tick(); tick();
    fin = 1'b0;
    drain("t3_drain");

    // Trigger while busy is dropped; held trigger does not retrigger
    mask = 8'hFF;
    exp_frame(2, 8'hFF);
    store_data = 2'd2;
    tick();
    tick();
    store_data = 2'd0;
    tick();
    store_data = 2'd1;
    tick();
    store_data = 2'd0;
    chk("t4_busy", busy, 1);
    chk("t4_drops", drops, 1);
    chk("t4_ovf", ovf, 1);
    drain("t4_drain");
    chk("t4_drops_after", drops, 1);

    // Reset mid-frame
    tready = 1'b0; mask = 8'hFF;
    store_data = 2'd2;
    tick();
    store_data = 2'd0;
    repeat (4) tick();
    chk("t6_pre_tvalid", tvalid, 1);
    rst = 1'b1;
    tick();
    chk("t6_tvalid", tvalid, 0);
    chk("t6_fill", fill, 0);
    chk("t6_ovf", ovf, 0);
    chk("t6_drops", drops, 0);
    chk("t6_busy", busy, 0);
    rst = 1'b0;
    tick();
    tready = 1'b1; mask = 8'h81;
    exp_frame(1, 8'h81);
    store_data = 2'd1;
    tick();
    store_data = 2'd0;
    drain("t6_drain");

    // Fill with tready low: 7 frames of 9 words fit, the 8th is dropped
    tready = 1'b0; mask = 8'hFF;
    for (int f = 0; f < 8; f++) begin
      if (f < 7) exp_frame(1, 8'hFF);
      store_data = 2'd1;
      tick();
      store_data = 2'd0;
      repeat (11) tick();
    end
    chk("t5_ovf", ovf, 1);
    chk("t5_drops", drops, 1);
    chk("t5_fill", fill, 63);
    drain("t5_drain");
    tick();
    chk("t5_fill_empty", fill, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
